// File: rtl/sram_lsu_pkg.sv
// Shared types and helpers for the SRAM load/store initiator.
// No state; pure definitions used by the align datapath and the top-level FSM.
package sram_lsu_pkg;

  localparam int DataW = 32;

  typedef enum logic [1:0] {
    BYTE    = 2'd0,
    HALF    = 2'd1,
    WORD    = 2'd2,
    ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Widen a per-byte lane enable into the SRAM's per-bit write mask.
  function automatic logic [DataW-1:0] byte_mask_to_bit_mask(input logic [3:0] bm);
    logic [DataW-1:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{bm[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_lsu_initiator_if.sv
// Bundles the core request/response channels and the SRAM port of the initiator.
// slave = initiator side; master = core/harness plus SRAM model side.
interface sram_lsu_initiator_if #(
  parameter int Aw = 15
);

  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [31:0]   req_addr_i;
  logic [1:0]    req_size_i;
  logic          req_unsigned_i;
  logic [31:0]   req_wdata_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;

  logic          sram_req_o;
  logic          sram_write_o;
  logic [Aw-1:0] sram_addr_o;
  logic [31:0]   sram_wdata_o;
  logic [31:0]   sram_wmask_o;
  logic [31:0]   sram_rdata_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  rsp_ready_i, sram_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output sram_req_o, sram_write_o, sram_addr_o, sram_wdata_o, sram_wmask_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    output rsp_ready_i, sram_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  sram_req_o, sram_write_o, sram_addr_o, sram_wdata_o, sram_wmask_o
  );

endinterface

// File: rtl/sram_lsu_align.sv
// Lane steering for misaligned accesses: store masks/data per beat and load merge/extend.
// Purely combinational, no latency, no flow control.
module sram_lsu_align
  import sram_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic [31:0] wdata,
  output logic [3:0]  bmask0,
  output logic [3:0]  bmask1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic        split,
  input  logic [31:0] rd_lo,
  input  logic [23:0] rd_hi,
  input  logic        is_unsigned,
  output logic [31:0] ld_data
);

  logic [3:0]  nmask;
  logic [7:0]  bm_wide;
  logic [63:0] wd_wide;
  logic [31:0] raw;

  always_comb begin
    nmask = 4'b0000;
    case (size)
      BYTE:    nmask = 4'b0001;
      HALF:    nmask = 4'b0011;
      WORD:    nmask = 4'b1111;
      default: nmask = 4'b0000;
    endcase
  end

  // Shifting across a double-width window lets the upper lanes spill into beat 1.
  assign bm_wide = {4'b0000, nmask} << off;
  assign wd_wide = {32'h0, wdata} << {off, 3'b000};
  assign bmask0  = bm_wide[3:0];
  assign bmask1  = bm_wide[7:4];
  assign wdata0  = wd_wide[31:0];
  assign wdata1  = wd_wide[63:32];
  assign split   = |bm_wide[7:4];

  always_comb begin
    raw = rd_lo;
    case (off)
      2'd0: raw = rd_lo;
      2'd1: raw = {rd_hi[7:0],  rd_lo[31:8]};
      2'd2: raw = {rd_hi[15:0], rd_lo[31:16]};
      2'd3: raw = {rd_hi[23:0], rd_lo[31:24]};
      default: raw = rd_lo;
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (size)
      BYTE:    ld_data = {{24{raw[7]  & ~is_unsigned}}, raw[7:0]};
      HALF:    ld_data = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
      WORD:    ld_data = raw;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/sram_lsu_initiator.sv
// Byte-addressed load/store engine over a single-port SRAM; 1-4 cycles request to response.
// One request in flight; req_ready only in IDLE, rsp held indefinitely while rsp_ready is low.
module sram_lsu_initiator
  import sram_lsu_pkg::*;
#(
  parameter int Depth = 1 << 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sram_lsu_initiator_if.slave  bus
);

  localparam int Aw = $clog2(Depth);

  state_e state, state_nxt;

  logic          lat_write;
  logic          lat_unsigned;
  size_e         lat_size;
  logic [1:0]    lat_off;
  logic [Aw-1:0] lat_w0;
  logic [31:0]   lat_wdata;
  logic [31:0]   rd0;

  logic          sram_req_q, sram_write_q;
  logic [Aw-1:0] sram_addr_q;
  logic [31:0]   sram_wdata_q, sram_wmask_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  logic          n_req, n_write;
  logic [Aw-1:0] n_addr;
  logic [31:0]   n_wdata, n_wmask;
  logic          n_rsp_valid, n_rsp_err;
  logic [31:0]   n_rsp_rdata;
  logic          capture;

  logic          hs;
  size_e         in_size;
  logic [Aw-1:0] in_w0;

  logic [1:0]    a_off;
  size_e         a_size;
  logic [31:0]   a_wdata;
  logic [3:0]    bmask0, bmask1;
  logic [31:0]   wdata0, wdata1;
  logic          split;
  logic [31:0]   rd_lo;
  logic [23:0]   rd_hi;
  logic [31:0]   ld_data;

  assign bus.req_ready_o = (state == IDLE) && !rst_i;
  assign hs              = bus.req_valid_i && bus.req_ready_o;
  assign in_size         = size_e'(bus.req_size_i);
  assign in_w0           = bus.req_addr_i[Aw+1:2];

  // In IDLE the datapath looks at the incoming request so beat 0 can be registered at the handshake.
  assign a_off   = (state == IDLE) ? bus.req_addr_i[1:0] : lat_off;
  assign a_size  = (state == IDLE) ? in_size             : lat_size;
  assign a_wdata = (state == IDLE) ? bus.req_wdata_i     : lat_wdata;

  // In WAIT the live SRAM data is the last beat: beat 1 when split, otherwise the only beat.
  assign rd_lo = split ? rd0 : bus.sram_rdata_i;
  assign rd_hi = split ? bus.sram_rdata_i[23:0] : 24'h0;

  sram_lsu_align u_align (
    .off         (a_off),
    .size        (a_size),
    .wdata       (a_wdata),
    .bmask0      (bmask0),
    .bmask1      (bmask1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .split       (split),
    .rd_lo       (rd_lo),
    .rd_hi       (rd_hi),
    .is_unsigned (lat_unsigned),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_nxt   = state;
    n_req       = 1'b0;
    n_write     = 1'b0;
    n_addr      = '0;
    n_wdata     = '0;
    n_wmask     = '0;
    n_rsp_valid = rsp_valid_q;
    n_rsp_rdata = rsp_rdata_q;
    n_rsp_err   = rsp_err_q;
    capture     = 1'b0;

    case (state)
      IDLE: begin
        if (hs) begin
          if (in_size == ILLEGAL) begin
            state_nxt   = RESP;
            n_rsp_valid = 1'b1;
            n_rsp_rdata = '0;
            n_rsp_err   = 1'b1;
          end else begin
            state_nxt = BEAT0;
            n_req     = 1'b1;
            n_write   = bus.req_write_i;
            n_addr    = in_w0;
            if (bus.req_write_i) begin
              n_wdata = wdata0;
              n_wmask = byte_mask_to_bit_mask(bmask0);
            end
          end
        end
      end

      BEAT0: begin
        if (split) begin
          state_nxt = BEAT1;
          n_req     = 1'b1;
          n_write   = lat_write;
          n_addr    = lat_w0 + Aw'(1);
          if (lat_write) begin
            n_wdata = wdata1;
            n_wmask = byte_mask_to_bit_mask(bmask1);
          end
        end else if (!lat_write) begin
          state_nxt = WAIT;
        end else begin
          state_nxt   = RESP;
          n_rsp_valid = 1'b1;
          n_rsp_rdata = '0;
          n_rsp_err   = 1'b0;
        end
      end

      BEAT1: begin
        if (lat_write) begin
          state_nxt   = RESP;
          n_rsp_valid = 1'b1;
          n_rsp_rdata = '0;
          n_rsp_err   = 1'b0;
        end else begin
          state_nxt = WAIT;
          capture   = 1'b1;
        end
      end

      WAIT: begin
        state_nxt   = RESP;
        n_rsp_valid = 1'b1;
        n_rsp_rdata = ld_data;
        n_rsp_err   = 1'b0;
      end

      RESP: begin
        if (bus.rsp_ready_i) begin
          state_nxt   = IDLE;
          n_rsp_valid = 1'b0;
          n_rsp_rdata = '0;
          n_rsp_err   = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= BYTE;
      lat_off      <= '0;
      lat_w0       <= '0;
      lat_wdata    <= '0;
      rd0          <= '0;
      sram_req_q   <= 1'b0;
      sram_write_q <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_wmask_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      sram_req_q   <= n_req;
      sram_write_q <= n_write;
      sram_addr_q  <= n_addr;
      sram_wdata_q <= n_wdata;
      sram_wmask_q <= n_wmask;
      rsp_valid_q  <= n_rsp_valid;
      rsp_rdata_q  <= n_rsp_rdata;
      rsp_err_q    <= n_rsp_err;
      if (hs) begin
        lat_write    <= bus.req_write_i;
        lat_unsigned <= bus.req_unsigned_i;
        lat_size     <= in_size;
        lat_off      <= bus.req_addr_i[1:0];
        lat_w0       <= in_w0;
        lat_wdata    <= bus.req_wdata_i;
      end
      if (capture) begin
        rd0 <= bus.sram_rdata_i;
      end
    end
  end

  assign bus.sram_req_o   = sram_req_q;
  assign bus.sram_write_o = sram_write_q;
  assign bus.sram_addr_o  = sram_addr_q;
  assign bus.sram_wdata_o = sram_wdata_q;
  assign bus.sram_wmask_o = sram_wmask_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_rdata_o  = rsp_rdata_q;
  assign bus.rsp_err_o    = rsp_err_q;

  a_no_sram_in_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    (state == RESP) |-> !sram_req_q);

  a_rsp_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (rsp_valid_q && !bus.rsp_ready_i) |=> (rsp_valid_q && $stable(rsp_rdata_q) && $stable(rsp_err_q)));

endmodule

// File: tb/tb_sram_lsu_initiator.sv
// Directed bench for sram_lsu_initiator with a behavioural single-port SRAM model.
module tb_sram_lsu_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sram_lsu_initiator_if #(.Aw(15)) bus();

  sram_lsu_initiator #(.Depth(1 << 15)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] mem [0:32767];

  // Reset preloads the words the directed vectors rely on.
  always @(posedge clk) begin
    if (rst) begin
      bus.sram_rdata_i <= 32'h0;
      mem[15'h0000]    <= 32'h80010000;
      mem[15'h003F]    <= 32'h00000000;
      mem[15'h0040]    <= 32'hDEADBEEF;
      mem[15'h0041]    <= 32'h44332211;
      mem[15'h0042]    <= 32'h88776655;
      mem[15'h0080]    <= 32'h00000000;
      mem[15'h7FFF]    <= 32'h00000000;
    end else if (bus.sram_req_o) begin
      if (bus.sram_write_o) begin
        mem[bus.sram_addr_o] <= (mem[bus.sram_addr_o] & ~bus.sram_wmask_o) |
                                (bus.sram_wdata_o & bus.sram_wmask_o);
        bus.sram_rdata_i <= 32'h0;
      end else begin
        bus.sram_rdata_i <= mem[bus.sram_addr_o];
      end
    end else begin
      bus.sram_rdata_i <= 32'h0;
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_nb;
    logic [14:0] a0;
    logic [31:0] m0;
    logic [31:0] d0;
    logic [14:0] a1;
    logic [31:0] m1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int nb;
    logic [14:0] ba [2];
    logic [31:0] bm [2];
    logic [31:0] bd [2];
    logic        bw [2];
    for (int k = 0; k < 2; k++) begin
      ba[k] = '0; bm[k] = '0; bd[k] = '0; bw[k] = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("v%0d req_ready", idx), 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i    = 1'b1;
    bus.req_write_i    = v.wr;
    bus.req_addr_i     = v.addr;
    bus.req_size_i     = v.size;
    bus.req_unsigned_i = v.uns;
    bus.req_wdata_i    = v.wdata;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    lat = 1;
    nb  = 0;
    while (!bus.rsp_valid_o && lat < 20) begin
      if (bus.sram_req_o) begin
        if (nb < 2) begin
          ba[nb] = bus.sram_addr_o;
          bm[nb] = bus.sram_wmask_o;
          bd[nb] = bus.sram_wdata_o;
          bw[nb] = bus.sram_write_o;
        end
        nb++;
      end
      @(negedge clk);
      lat++;
    end
    if (bus.sram_req_o) nb++;
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d rdata", idx), bus.rsp_rdata_o, v.exp_rdata);
    chk($sformatf("v%0d err", idx), 32'(bus.rsp_err_o), 32'(v.exp_err));
    chk($sformatf("v%0d beats", idx), 32'(nb), 32'(v.exp_nb));
    for (int k = 0; k < 2; k++) begin
      if (k < v.exp_nb) begin
        chk($sformatf("v%0d b%0d addr", idx, k), 32'(ba[k]), 32'(k == 0 ? v.a0 : v.a1));
        chk($sformatf("v%0d b%0d wmask", idx, k), bm[k], (k == 0 ? v.m0 : v.m1));
        chk($sformatf("v%0d b%0d wdata", idx, k), bd[k], (k == 0 ? v.d0 : v.d1));
        chk($sformatf("v%0d b%0d write", idx, k), 32'(bw[k]), 32'(v.wr));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t chkv;
    bus.req_valid_i    = 1'b0;
    bus.req_write_i    = 1'b0;
    bus.req_addr_i     = 32'h0;
    bus.req_size_i     = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_wdata_i    = 32'h0;
    bus.rsp_ready_i    = 1'b1;

    //           wr   addr          sz    uns   wdata          rdata          err  lat nb  a0        m0            d0            a1        m1            d1
    vecs[0]  = '{1'b0, 32'h00000100, 2'd2, 1'b0, 32'h00000000, 32'hDEADBEEF, 1'b0, 3, 1, 15'h0040, 32'h00000000, 32'h00000000, 15'h0000, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 32'h00000103, 2'd0, 1'b0, 32'h000000A5, 32'h00000000, 1'b0, 2, 1, 15'h0040, 32'hFF000000, 32'hA5000000, 15'h0000, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 32'h00000106, 2'd2, 1'b0, 32'h00000000, 32'h66554433, 1'b0, 4, 2, 15'h0041, 32'h00000000, 32'h00000000, 15'h0042, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 32'h00000002, 2'd1, 1'b0, 32'h00000000, 32'hFFFF8001, 1'b0, 3, 1, 15'h0000, 32'h00000000, 32'h00000000, 15'h0000, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 32'h00000002, 2'd1, 1'b1, 32'h00000000, 32'h00008001, 1'b0, 3, 1, 15'h0000, 32'h00000000, 32'h00000000, 15'h0000, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 32'h0001FFFE, 2'd2, 1'b0, 32'h11223344, 32'h00000000, 1'b0, 3, 2, 15'h7FFF, 32'hFFFF0000, 32'h33440000, 15'h0000, 32'h0000FFFF, 32'h00001122};
    vecs[6]  = '{1'b0, 32'h0001FFFE, 2'd2, 1'b0, 32'h00000000, 32'h11223344, 1'b0, 4, 2, 15'h7FFF, 32'h00000000, 32'h00000000, 15'h0000, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 32'h00000103, 2'd0, 1'b0, 32'h00000000, 32'hFFFFFFA5, 1'b0, 3, 1, 15'h0040, 32'h00000000, 32'h00000000, 15'h0000, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 32'h00000101, 2'd0, 1'b1, 32'h00000000, 32'h000000BE, 1'b0, 3, 1, 15'h0040, 32'h00000000, 32'h00000000, 15'h0000, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, 32'h000000FF, 2'd1, 1'b0, 32'h1234CAFE, 32'h00000000, 1'b0, 3, 2, 15'h003F, 32'hFF000000, 32'hFE000000, 15'h0040, 32'h000000FF, 32'h001234CA};
    vecs[10] = '{1'b0, 32'h000000FF, 2'd1, 1'b0, 32'h00000000, 32'hFFFFCAFE, 1'b0, 4, 2, 15'h003F, 32'h00000000, 32'h00000000, 15'h0040, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 32'h00000100, 2'd3, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 15'h0000, 32'h00000000, 32'h00000000, 15'h0000, 32'h0, 32'h0};
    vecs[12] = '{1'b1, 32'h00000200, 2'd2, 1'b0, 32'h01020304, 32'h00000000, 1'b0, 2, 1, 15'h0080, 32'hFFFFFFFF, 32'h01020304, 15'h0000, 32'h0, 32'h0};
    vecs[13] = '{1'b0, 32'h00000200, 2'd2, 1'b0, 32'h00000000, 32'h01020304, 1'b0, 3, 1, 15'h0080, 32'h00000000, 32'h00000000, 15'h0000, 32'h0, 32'h0};

    // Reset state, then readiness in the first cycle after release.
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst sram_req", 32'(bus.sram_req_o), 32'd0);
    chk("rst sram_wmask", bus.sram_wmask_o, 32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata_o, 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst req_ready", 32'(bus.req_ready_o), 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], i);
    end

    // Illegal size under back-pressure.
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = 32'h00000040;
    bus.req_size_i  = 2'd3;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("bp T+1 rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("bp T+1 err", 32'(bus.rsp_err_o), 32'd1);
    chk("bp T+1 sram_req", 32'(bus.sram_req_o), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d rsp_valid", c), 32'(bus.rsp_valid_o), 32'd1);
      chk($sformatf("bp hold%0d err", c), 32'(bus.rsp_err_o), 32'd1);
      chk($sformatf("bp hold%0d rdata", c), bus.rsp_rdata_o, 32'd0);
      chk($sformatf("bp hold%0d req_ready", c), 32'(bus.req_ready_o), 32'd0);
      chk($sformatf("bp hold%0d sram_req", c), 32'(bus.sram_req_o), 32'd0);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp release rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("bp release req_ready", 32'(bus.req_ready_o), 32'd1);

    // Reset asserted while a split load is on its second beat.
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = 32'h00000106;
    bus.req_size_i  = 2'd2;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("mid-rst beat0 req", 32'(bus.sram_req_o), 32'd1);
    chk("mid-rst beat0 addr", 32'(bus.sram_addr_o), 32'h41);
    @(negedge clk);
    chk("mid-rst beat1 addr", 32'(bus.sram_addr_o), 32'h42);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst sram_req", 32'(bus.sram_req_o), 32'd0);
    chk("mid-rst sram_addr", 32'(bus.sram_addr_o), 32'd0);
    chk("mid-rst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("mid-rst req_ready", 32'(bus.req_ready_o), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post mid-rst%0d rsp_valid", c), 32'(bus.rsp_valid_o), 32'd0);
    end

    chkv = vecs[0];
    run_vec(chkv, 100);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_lsu_initiator.md
# sram_lsu_initiator

Initiator-side engine for the single-port SRAM request/response interface: `req`/`write`/`addr`/`wdata`/bit-`wmask` in, with `rdata` registered one cycle later. It accepts byte-addressed load/store requests from a core-side valid/ready channel, splits word-misaligned accesses into two SRAM beats, and merges and extends read data. It returns one response per request on a valid/ready channel. It sits between a core LSU, or a test harness, and the SRAM memory model.

## Interface
Parameters:
- `Depth`, `1 << 15`: SRAM depth in 32-bit words; must be a power of two.
- `Aw`, `$clog2(Depth)` (localparam): SRAM word-address width.
- Data width is fixed at 32 bits.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset; **synchronous, active-high**.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready.
- `req_write_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  32  byte address.
- `req_size_i`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned_i`  in  1  zero-extend loads when set.
- `req_wdata_i`  in  32  store data, right-aligned.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response ready.
- `rsp_rdata_o`  out  32  extended load data; 0 for stores.
- `rsp_err_o`  out  1  illegal size.
- `sram_req_o`  out  1  SRAM request.
- `sram_write_o`  out  1  SRAM write.
- `sram_addr_o`  out  Aw  SRAM word address.
- `sram_wdata_o`  out  32  SRAM write data.
- `sram_wmask_o`  out  32  SRAM bit-level write mask.
- `sram_rdata_i`  in  32  SRAM read data, valid the cycle after a read beat.

## Operation
- **FSM states:** IDLE, BEAT0, BEAT1, WAIT, RESP.
- **IDLE:**
  - `req_ready_o` is 1 in IDLE and 0 in every other state.
  - On handshake, latch the request and compute lane data:
    - `off = addr[1:0]` and `n = 1 << size`.
    - `split = off + n > 4`.
    - `w0 = addr[Aw+1:2]`.
    - `w1 = w0 + 1` modulo `Depth`, so the word index wraps to 0.
  - Size 3 goes to RESP with `err = 1`, no SRAM traffic, and `rdata = 0`.
  - Any other size goes to BEAT0.
- **BEAT0:**
  - Drive `sram_req_o = 1`, `sram_addr_o = w0`.
  - Byte lanes `off` .. `min(3, off + n - 1)`.
  - Next state:
    - If `split`: BEAT1.
    - Else if load: WAIT.
    - Else: RESP.
- **BEAT1:**
  - Drive `sram_addr_o = w1`, byte lanes 0 .. `off + n - 5`.
  - For loads, capture `sram_rdata_i`, which holds the beat-0 result.
  - Next state: WAIT for loads, RESP for stores.
- **WAIT:** capture `sram_rdata_i` (the last beat), then go to RESP.
- **Stores:**
  - `sram_wdata_o = wdata << 8*off`; the upper bytes spill into beat 1.
  - `sram_wmask_o` is all-ones over the active byte lanes of each beat.
- **Loads:**
  - Assemble bytes little-endian from the captured beats, starting at `off`.
  - Sign-extend from bit `8n-1` unless `req_unsigned_i` is set.
- **RESP:**
  - Hold `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o` stable until `rsp_ready_i`, then go to IDLE.
  - The earliest next request is accepted in the cycle after the response handshake.
- **Idle SRAM outputs:** when `sram_req_o = 0`, `sram_write_o`, `sram_addr_o`, `sram_wdata_o` and `sram_wmask_o` are all 0.

## Timing
- All outputs are registered, except `req_ready_o`, which is decoded from state.
- **Reset:** while `rst_i` is high, the state is IDLE and every output is 0, including `req_ready_o`. The block is ready in the first cycle after reset deasserts.
- **Latency** (request handshake at cycle T until `rsp_valid_o` is high):

| Access | `rsp_valid_o` high at |
|---|---|
| Aligned store | T+2 |
| Split store | T+3 |
| Aligned load | T+3 |
| Split load | T+4 |
| Illegal size | T+1 |

- **Beat timing:** beat 0 is on the SRAM port at T+1; beat 1, if present, at T+2.
- **Back-pressure:** `rsp_ready_i` low holds RESP indefinitely. No SRAM traffic occurs while in RESP.
- **Reset mid-operation:** the block returns to IDLE in the next cycle, `sram_req_o` drops, and the response is discarded. A split store may already have committed beat 0; this is accepted behaviour.
- **SRAM read data:** `sram_rdata_i` is sampled only in BEAT1 and WAIT of loads. The SRAM returns 0 after writes and idle cycles, and that value is never used.

## Structure
- **Package `sram_lsu_pkg`:**
  - `size_e` (BYTE, HALF, WORD, ILLEGAL).
  - `state_e`.
  - Function `byte_mask_to_bit_mask` (4 → 32 bits).
- **Sub-module `sram_lsu_align`** (purely combinational):
  - Inputs: `off`, `size`, store data.
  - Outputs: per-beat byte masks, shifted write data, and `split`.
  - Also provides the load merge and extend from two 32-bit words.
- **Top level:** FSM, request latch, beat registers, and the response register.

## Test plan
1. **Aligned load.** LW `0x100`, SRAM word `0x40 = 0xDEADBEEF`.
   - One read beat with `addr = 0x40` at T+1.
   - `rsp_rdata_o = 0xDEADBEEF`, `err = 0`, `rsp_valid_o` at T+3.
2. **Byte store.** SB `0x103`, data `0xA5`.
   - One beat: `addr = 0x40`, `wmask = 0xFF000000`, `wdata = 0xA5000000`.
   - Response at T+2 with `rdata = 0`.
3. **Split load.** LW `0x106`, words `0x41 = 0x44332211`, `0x42 = 0x88776655`.
   - Read beats at `0x41` then `0x42`.
   - `rsp_rdata_o = 0x66554433` at T+4.
4. **Half-word extension.** LH `0x002`, word `0 = 0x80010000`.
   - Signed: `rdata = 0xFFFF8001`.
   - With `req_unsigned_i = 1`: `0x00008001`.
5. **Address wrap.** SW at byte `0x1FFFE` (`Depth = 1 << 15`), data `0x11223344`.
   - Beat 0: `addr 0x7FFF`, `wmask 0xFFFF0000`, `wdata 0x33440000`.
   - Beat 1: `addr 0x0000`, `wmask 0x0000FFFF`, `wdata 0x00001122`.
6. **Illegal size, back-pressure and reset.**
   - Size 3: no `sram_req_o`, `err = 1` at T+1.
   - Hold `rsp_ready_i = 0` for 5 cycles: outputs stay stable and `req_ready_o` stays 0.
   - Assert `rst_i` during BEAT1: all outputs are 0 the next cycle.
